// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer merging load-use, branch and data-memory hazards
// Control outputs are combinational; state, memory-wait watchdog and perf counters are registered.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait_cnt;
    logic [WW-1:0]    w_wait_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_mem_stall;
    logic             w_flush_apply;
    logic             w_stall_inc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_wait_next    = r_wait_cnt;
        w_mem_stall    = 1'b0;
        w_flush_apply  = 1'b0;
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_write_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        err_o          = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_mem_stall = dmem_req_i & ~dmem_ack_i;
                if (w_mem_stall) begin
                    w_next      = ST_WAIT;
                    w_wait_next = '0;
                end
            end
            ST_WAIT: begin
                w_mem_stall = ~dmem_ack_i;
                if (dmem_ack_i) begin
                    w_next = ST_RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next = ST_ERR;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_next = ST_ERR;
            end
        endcase

        if (r_state == ST_ERR) begin
            memwb_bubble_o = 1'b1;
            err_o          = 1'b1;
        end else if (w_mem_stall) begin
            memwb_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            // A taken branch squashes the load-use bubble: the dependent instruction is discarded anyway.
            w_flush_apply = 1'b1;
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_write_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_write_o = 1'b1;
        end else if (load_use_i) begin
            idex_write_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_write_o = 1'b1;
        end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            exmem_write_o = 1'b1;
        end

        // Reset forces every control quiet, including the bubble.
        if (rst_i) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            ifid_flush_o   = 1'b0;
            idex_write_o   = 1'b0;
            idex_flush_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b0;
            err_o          = 1'b0;
            w_flush_apply  = 1'b0;
        end
    end

    assign w_stall_inc = (r_state != ST_ERR) && !pc_write_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_apply && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
// Vector table, directed multi-cycle sequences and a random run against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int TO   = 16;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          lu, br, req, ack;
    logic          pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bub, err;
    logic [1:0]    st;
    logic [CW-1:0] scnt, fcnt;

    pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .load_use_i(lu), .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
        .idex_write_o(idex_w), .idex_flush_o(idex_f), .exmem_write_o(exmem_w),
        .memwb_bubble_o(bub), .err_o(err), .state_o(st),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    always #5 clk = ~clk;

    wire [6:0] ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bub};

    int    n_pass = 0;
    int    n_tot  = 0;
    string tag    = "init";

    // Model: a pending access plus the number of stall cycles it has cost so far.
    bit m_wait, m_err;
    int m_stalled, m_scnt, m_fcnt;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
    endtask

    function automatic bit model_mem_stall();
        if (m_err) return 1'b0;
        return m_wait ? !ack : (req && !ack);
    endfunction

    function automatic logic [6:0] model_ctl(output bit stall, output bit flush);
        stall = 1'b0;
        flush = 1'b0;
        if (m_err) return 7'b0000001;
        if (model_mem_stall()) begin stall = 1'b1; return 7'b0000001; end
        if (br) begin flush = 1'b1; return 7'b1111110; end
        if (lu) begin stall = 1'b1; return 7'b0001110; end
        return 7'b1101010;
    endfunction

    function automatic int model_state();
        return m_err ? 2 : (m_wait ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_stalled = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    // One clock cycle: drive inputs, check combinational controls mid-cycle, then registered state after the edge.
    task automatic cycle(input bit l, input bit b, input bit r, input bit a);
        bit        s_st, s_fl, ms;
        logic [6:0] e;
        lu = l; br = b; req = r; ack = a;
        @(negedge clk);
        e  = model_ctl(s_st, s_fl);
        ms = model_mem_stall();
        chk("ctl", int'(ctl), int'(e));
        chk("err", int'(err), int'(m_err));
        chk("state", int'(st), model_state());
        if (!m_err) begin
            if (s_st && m_scnt < CMAX) m_scnt++;
            if (s_fl && m_fcnt < CMAX) m_fcnt++;
            if (ms) begin
                m_wait = 1;
                m_stalled++;
                if (m_stalled == TO + 1) m_err = 1;
            end else if (m_wait) begin
                m_wait = 0;
                m_stalled = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("stall_cnt", int'(scnt), m_scnt);
        chk("flush_cnt", int'(fcnt), m_fcnt);
        chk("state_post", int'(st), model_state());
    endtask

    // Called at posedge+1: asserts reset mid-cycle, checks quiet outputs, releases after the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ctl", int'(ctl), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_state", int'(st), 0);
        chk("rst_cnt", int'(scnt) + int'(fcnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         l, b, r, a;
        logic [6:0] exp;
        int         e_stall, e_flush;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0, 0, 0, 0, 7'b1101010, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 7'b0001110, 1, 0};
        vecs[2] = '{0, 1, 0, 0, 7'b1111110, 0, 1};
        vecs[3] = '{1, 1, 0, 0, 7'b1111110, 0, 1};
        vecs[4] = '{0, 0, 1, 0, 7'b0000001, 1, 0};
        vecs[5] = '{0, 0, 1, 1, 7'b1101010, 0, 0};
        vecs[6] = '{1, 1, 1, 0, 7'b0000001, 1, 0};
        vecs[7] = '{1, 1, 1, 1, 7'b1111110, 0, 1};
        vecs[8] = '{1, 0, 1, 1, 7'b0001110, 1, 0};

        rst = 1'b1; lu = 0; br = 0; req = 0; ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        tag = "reset_mid_wait";
        cycle(0, 0, 1, 0);
        req = 1; ack = 0;
        do_reset();
        cycle(0, 0, 0, 0);
        chk("after_rst_pc", int'(pc_w), 1);

        for (int i = 0; i < 9; i++) begin
            tag = $sformatf("vec%0d", i);
            do_reset();
            lu = vecs[i].l; br = vecs[i].b; req = vecs[i].r; ack = vecs[i].a;
            @(negedge clk);
            chk("tbl_ctl", int'(ctl), int'(vecs[i].exp));
            @(posedge clk);
            #1;
            chk("tbl_stall", int'(scnt), vecs[i].e_stall);
            chk("tbl_flush", int'(fcnt), vecs[i].e_flush);
        end

        tag = "mem_wait_branch";
        do_reset();
        repeat (3) begin
            cycle(0, 1, 1, 0);
            chk("wait_flush", int'(ifid_f) + int'(idex_f), 0);
        end
        lu = 0; br = 1; req = 1; ack = 1;
        @(negedge clk);
        chk("ack_state", int'(st), 1);
        chk("ack_ctl", int'(ctl), 7'b1111110);
        @(posedge clk);
        #1;
        chk("rel_state", int'(st), 0);
        chk("rel_stall", int'(scnt), 3);
        chk("rel_flush", int'(fcnt), 1);

        tag = "timeout";
        do_reset();
        repeat (TO + 1) cycle(0, 0, 1, 0);
        chk("to_state", int'(st), 2);
        chk("to_err", int'(err), 1);
        chk("to_stall", int'(scnt), TO + 1);
        repeat (3) cycle(1, 1, 1, 1);
        chk("to_sticky", int'(st), 2);
        do_reset();

        tag = "random";
        for (int i = 0; i < 3000; i++) begin
            if ((m_err && $urandom_range(3) == 0) || $urandom_range(199) == 0) do_reset();
            cycle($urandom_range(3) == 0, $urandom_range(4) == 0,
                  $urandom_range(1) == 1, $urandom_range(3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline stall/flush sequencer for the 5-stage MIPS pipeline. Merges three hazard sources into one set of per-stage write-enable, flush and bubble controls:
- the load-use signal from hazard detection;
- taken-branch resolution from EX;
- a multi-cycle data-memory handshake from MEM.

Adds a memory-wait watchdog with a sticky error state, plus stall and flush performance counters.

## Interface

- TIMEOUT, 16: max MEM_WAIT cycles without ack before ERROR (≥2).
- CNT_W, 16: width of performance counters.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- load_use_i  in  1  load-use hazard from ID/EX vs IF/ID compare.
- branch_taken_i  in  1  branch/jump resolved taken in EX this cycle.
- dmem_req_i  in  1  MEM stage holds a load/store this cycle.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  clear IF/ID to NOP.
- idex_write_o  out  1  ID/EX register enable.
- idex_flush_o  out  1  load NOP controls into ID/EX.
- exmem_write_o  out  1  EX/MEM register enable.
- memwb_bubble_o  out  1  load NOP into MEM/WB.
- err_o  out  1  sticky memory-timeout error.
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, ERROR=2.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 outside ERROR, saturating.
- flush_cnt_o  out  CNT_W  cycles with branch flush applied, saturating.

## Operation

**States**
- RUN, MEM_WAIT, ERROR. State and counters are registered; control outputs are combinational from state and inputs.
- mem_stall is 1 when:
  - in RUN: dmem_req_i & ~dmem_ack_i;
  - in MEM_WAIT: ~dmem_ack_i.

**Control priority (RUN and MEM_WAIT)**, highest first:
1. **mem_stall:** all write enables 0, both flushes 0, memwb_bubble_o=1.
2. **branch_taken_i:** all enables 1, ifid_flush_o=1, idex_flush_o=1. load_use_i is ignored.
3. **load_use_i:** pc_write_o=0, ifid_write_o=0, idex_write_o=1, idex_flush_o=1, exmem_write_o=1.
4. **Otherwise:** all enables 1, flushes 0, bubble 0.

**ERROR state**
- All enables 0, flushes 0, memwb_bubble_o=1, err_o=1.

**Transitions**
- RUN → MEM_WAIT when dmem_req_i & ~dmem_ack_i. wait_cnt is cleared to 0.
- MEM_WAIT with dmem_ack_i → RUN.
  - The ack cycle is the release cycle: rules 2–4 apply in the same cycle, with no extra latency.
- MEM_WAIT with ~dmem_ack_i:
  - wait_cnt == TIMEOUT-1 → ERROR;
  - else wait_cnt += 1.
- ERROR is absorbing; only rst_i exits it.
- dmem_req_i & dmem_ack_i in RUN: no stall, stay in RUN.

**Counters**
- wait_cnt is $clog2(TIMEOUT) bits wide.
- stall_cnt_o increments on every non-ERROR cycle with pc_write_o=0 (memory and load-use stalls).
- flush_cnt_o increments on every cycle where rule 2 is applied.
- Both saturate at 2^CNT_W-1 and never wrap.

**Inputs held during a stall**
- branch_taken_i and load_use_i are stable during a memory stall because ID/EX and EX/MEM are held. They are acted on in the release cycle.

## Timing

- **Reset:** asynchronous. While rst_i=1:
  - state_o=0, wait_cnt=0, counters 0, err_o=0;
  - all enables 0, flushes 0, memwb_bubble_o=0.
- **First cycle after deassertion:** RUN rules apply.
- **Reset mid-MEM_WAIT or in ERROR:** returns to RUN immediately. No pending stall or error survives.
- **Control latency:** 0 cycles. Outputs respond combinationally in the same cycle as the inputs.
- **Counter latency:** counters update on the clock edge ending the qualifying cycle.
- **Memory stall length:**
  - an access acked k cycles after the first request cycle stalls exactly k cycles (k=0: none);
  - if never acked, TIMEOUT+1 stall cycles, then ERROR on the next edge.
- **ERROR counting:** stall_cnt_o stops incrementing in ERROR.

## Test plan

- **Reset:** assert rst_i mid-cycle with dmem_req_i=1, ack=0 → outputs immediately at reset values, state_o=0. After release, the no-hazard rule gives all enables 1.
- **Load-use only:** load_use_i=1 for 1 cycle → pc_write_o=0, ifid_write_o=0, idex_flush_o=1 that cycle; stall_cnt_o=1 after the edge.
- **Branch vs load-use:** branch_taken_i=1 and load_use_i=1 together → ifid_flush_o=idex_flush_o=1, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
- **Memory wait:** dmem_req_i=1 with ack after 3 cycles → 3 stall cycles with memwb_bubble_o=1. In the ack cycle, state_o=1 with all enables 1; state_o=0 on the next cycle; stall_cnt_o=3.
- **Release with branch:** memory wait with branch_taken_i held high → flushes stay 0 during the wait, then =1 only in the ack cycle; flush_cnt_o=1.
- **Timeout:** TIMEOUT=16, ack never arrives → 17 stall cycles, then state_o=2 and err_o=1. These persist with ack asserted until rst_i; stall_cnt_o=17.
